// File: rtl/countdown_timer.sv
// Down-counting timer with one-shot and auto-reload modes.
// A load starts the countdown; terminal count raises a one-cycle expire pulse.
//
// state | meaning
// IDLE  | waiting for a load, count_out held at 0, load_ready high
// RUN   | counting down on count_enable, busy high
module countdown_timer #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    load_periodic,
  input  logic                    count_enable,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    expire_flag,
  output logic                    busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);

  state_t                  state_q, state_d;
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic [NUM_CNT_BITS-1:0] period_q, period_d;
  logic                    mode_q, mode_d;
  logic                    expire_q, expire_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= CNT_ZERO;
      period_q <= CNT_ZERO;
      mode_q   <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      expire_q <= expire_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    mode_d   = mode_q;
    expire_d = 1'b0;

    if (clear) begin
      state_d = IDLE;
      count_d = CNT_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          count_d = CNT_ZERO;
          if (load_valid) begin
            if (load_val == CNT_ZERO) begin
              // zero-length countdown: expire immediately, never enter RUN
              expire_d = 1'b1;
            end else begin
              count_d  = load_val;
              period_d = load_val;
              mode_d   = load_periodic;
              state_d  = RUN;
            end
          end
        end
        RUN: begin
          if (count_enable) begin
            if (count_q > CNT_ONE) begin
              count_d = count_q - CNT_ONE;
            end else begin
              // terminal count; periodic reload happens in the same cycle
              expire_d = 1'b1;
              if (mode_q) begin
                count_d = period_q;
              end else begin
                count_d = CNT_ZERO;
                state_d = IDLE;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
          count_d = CNT_ZERO;
        end
      endcase
    end
  end

  assign load_ready  = (state_q == IDLE);
  assign busy        = (state_q == RUN);
  assign count_out   = count_q;
  assign expire_flag = expire_q;

endmodule
